// File: rtl/mult28x32.sv
// ----------------------------------------------------------------------------
// mult28x32
//
// Signed 28 x 32 -> 60 bit multiplier with a registered product, used by the
// interpolation FIR datapath (one instance per channel, shared coefficient).
// The product is exact: no rounding, truncation or saturation. The consumer
// scales the result.
//
// Ports:
//   pclk     in   1   system clock, rising edge active
//   reset_n  in   1   asynchronous active-low reset, clears every register
//   a        in  28   signed multiplicand (sample slice)
//   b        in  32   signed multiplier (coefficient)
//   y        out 60   signed product a*b, registered
//
// Build option:
//   MULT28X32_PIPE_EN  when defined, a and b are registered before the
//                      multiplier (latency 2). Otherwise latency is 1.
// ----------------------------------------------------------------------------
module mult28x32 (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic [27:0] a,
    input  logic [31:0] b,
    output logic [59:0] y
);

    logic [27:0] a_q;
    logic [31:0] b_q;

`ifdef MULT28X32_PIPE_EN
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            a_q <= a;
            b_q <= b;
        end
    end
`else
    assign a_q = a;
    assign b_q = b;
`endif

    // Partial-product decomposition:
    //   a = a_hi * 2^14 + a_lo   (a_hi signed 14 bits, a_lo unsigned 14 bits)
    //   b = b_hi * 2^16 + b_lo   (b_hi signed 16 bits, b_lo unsigned 16 bits)
    // Every term is formed in 60-bit two's complement, so the wrap-around of
    // the modulo-2^60 sum yields exactly the signed product.
    logic [59:0] a_hi_x;
    logic [59:0] a_lo_x;
    logic [59:0] b_hi_x;
    logic [59:0] b_lo_x;

    assign a_hi_x = {{46{a_q[27]}}, a_q[27:14]};
    assign a_lo_x = {46'b0, a_q[13:0]};
    assign b_hi_x = {{44{b_q[31]}}, b_q[31:16]};
    assign b_lo_x = {44'b0, b_q[15:0]};

    logic [59:0] pp_hh;
    logic [59:0] pp_hl;
    logic [59:0] pp_lh;
    logic [59:0] pp_ll;
    logic [59:0] product;

    assign pp_hh = a_hi_x * b_hi_x;
    assign pp_hl = a_hi_x * b_lo_x;
    assign pp_lh = a_lo_x * b_hi_x;
    assign pp_ll = a_lo_x * b_lo_x;

    assign product = (pp_hh << 30) + (pp_hl << 14) + (pp_lh << 16) + pp_ll;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            y <= '0;
        end else begin
            y <= product;
        end
    end

endmodule

// File: tb/tb_mult28x32.sv
// ----------------------------------------------------------------------------
// tb_mult28x32
//
// Self-checking bench for mult28x32. Expected products come from a 64-bit
// signed integer model; latency follows MULT28X32_PIPE_EN.
// ----------------------------------------------------------------------------
module tb_mult28x32;

`ifdef MULT28X32_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        pclk = 1'b0;
    logic        reset_n;
    logic [27:0] a;
    logic [31:0] b;
    logic [59:0] y;

    int checks   = 0;
    int failures = 0;

    mult28x32 dut (
        .pclk    (pclk),
        .reset_n (reset_n),
        .a       (a),
        .b       (b),
        .y       (y)
    );

    always #5 pclk = ~pclk;

    function automatic logic [59:0] ref_prod(input logic [27:0] av, input logic [31:0] bv);
        longint signed ai;
        longint signed bi;
        longint signed p;
        logic [63:0]   pv;
        ai = longint'($signed(av));
        bi = longint'($signed(bv));
        p  = ai * bi;
        pv = p;
        return pv[59:0];
    endfunction

    function automatic logic [27:0] rand_a();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 28'h8000000;
        if (sel == 1) return 28'h7FFFFFF;
        if (sel == 2) return 28'h0;
        return 28'($urandom());
    endfunction

    function automatic logic [31:0] rand_b();
        int sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return 32'h80000000;
        if (sel == 1) return 32'h7FFFFFFF;
        if (sel == 2) return 32'hFFFFFFFF;
        return $urandom();
    endfunction

    task automatic test_reset();
        logic [59:0] exp;
        reset_n = 1'b0;
        a = 28'd5;
        b = 32'd7;
        #3;
        checks++;
        if (y !== 60'd0) begin
            failures++;
            $display("FAIL reset_async: got %h expected %h", y, 60'd0);
        end
        repeat (3) @(posedge pclk);
        #1;
        checks++;
        if (y !== 60'd0) begin
            failures++;
            $display("FAIL reset_held: got %h expected %h", y, 60'd0);
        end
        @(negedge pclk);
        reset_n = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge pclk);
            exp = (k == LAT) ? 60'd35 : 60'd0;
            checks++;
            if (y !== exp) begin
                failures++;
                $display("FAIL reset_release edge %0d: got %h expected %h", k, y, exp);
            end
        end
    endtask

    task automatic test_directed();
        logic [27:0] va [8];
        logic [31:0] vb [8];
        logic [59:0] ve [8];
        va[0] = 28'h0000001; vb[0] = 32'h00000001; ve[0] = 60'h000000000000001;
        va[1] = 28'hFFFFFFD; vb[1] = 32'h00000004; ve[1] = 60'hFFFFFFFFFFFFFF4;
        va[2] = 28'h8000000; vb[2] = 32'h80000000; ve[2] = 60'h400000000000000;
        va[3] = 28'h7FFFFFF; vb[3] = 32'hFFFFFFFF; ve[3] = 60'hFFFFFFFF8000001;
        va[4] = 28'h8000000; vb[4] = 32'h7FFFFFFF; ve[4] = 60'hC00000008000000;
        va[5] = 28'hFFFFFFF; vb[5] = 32'hFFFFFFFF; ve[5] = 60'h000000000000001;
        va[6] = 28'h0000000; vb[6] = 32'h12345678; ve[6] = 60'h000000000000000;
        va[7] = 28'h7FFFFFF; vb[7] = 32'h7FFFFFFF; ve[7] = 60'h3FFFFFF78000001;
        for (int i = 0; i < 8; i++) begin
            @(negedge pclk);
            a = va[i];
            b = vb[i];
            repeat (LAT) @(negedge pclk);
            checks++;
            if (y !== ve[i]) begin
                failures++;
                $display("FAIL directed[%0d] a=%h b=%h: got %h expected %h", i, va[i], vb[i], y, ve[i]);
            end
        end
    endtask

    task automatic test_streaming();
        logic [59:0] exp_q[$];
        logic [59:0] exp;
        int          n_fail_print;
        n_fail_print = 0;
        for (int i = 0; i < 10000 + LAT; i++) begin
            @(negedge pclk);
            if (i >= LAT) begin
                exp = exp_q.pop_front();
                checks++;
                if (y !== exp) begin
                    failures++;
                    if (n_fail_print < 10) begin
                        $display("FAIL stream[%0d]: got %h expected %h", i - LAT, y, exp);
                        n_fail_print++;
                    end
                end
            end
            if (i < 10000) begin
                a = rand_a();
                b = rand_b();
                exp_q.push_back(ref_prod(a, b));
            end
        end
    endtask

    task automatic test_async_reset();
        logic [59:0] exp;
        @(negedge pclk);
        a = 28'h1234567;
        b = 32'h89ABCDEF;
        repeat (LAT) @(negedge pclk);
        exp = ref_prod(28'h1234567, 32'h89ABCDEF);
        checks++;
        if (y !== exp) begin
            failures++;
            $display("FAIL pre_reset_value: got %h expected %h", y, exp);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (y !== 60'd0) begin
            failures++;
            $display("FAIL midstream_async_clear: got %h expected %h", y, 60'd0);
        end
        a = 28'h0ABCDEF;
        b = 32'h00000123;
        @(posedge pclk);
        #1;
        checks++;
        if (y !== 60'd0) begin
            failures++;
            $display("FAIL midstream_held: got %h expected %h", y, 60'd0);
        end
        @(negedge pclk);
        reset_n = 1'b1;
        #1;
        checks++;
        if (y !== 60'd0) begin
            failures++;
            $display("FAIL release_no_edge: got %h expected %h", y, 60'd0);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge pclk);
            exp = (k == LAT) ? ref_prod(28'h0ABCDEF, 32'h00000123) : 60'd0;
            checks++;
            if (y !== exp) begin
                failures++;
                $display("FAIL post_reset edge %0d: got %h expected %h", k, y, exp);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_directed();
        test_streaming();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
